// File: rtl/color_correction_pipe.sv
// Three-stage 3x3 colour matrix with saturation.
// Double-buffered coefficients swap on a frame start.
module color_correction_pipe #(
  parameter int DATA_W    = 16,
  parameter int COEF_W    = 12,
  parameter int FRAC_BITS = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     in_sof,
  input  logic [DATA_W-1:0]        in_r,
  input  logic [DATA_W-1:0]        in_g,
  input  logic [DATA_W-1:0]        in_b,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     out_sof,
  output logic [DATA_W-1:0]        out_r,
  output logic [DATA_W-1:0]        out_g,
  output logic [DATA_W-1:0]        out_b,
  input  logic                     bypass,
  input  logic                     coef_we,
  input  logic [3:0]               coef_addr,
  input  logic signed [COEF_W-1:0] coef_wdata,
  input  logic                     coef_commit,
  output logic                     commit_pending
);

  localparam int PW = DATA_W + COEF_W + 1;
  localparam int SW = DATA_W + COEF_W + 3;

  typedef logic signed [COEF_W-1:0] coef_t;

  localparam coef_t DEF [9] = '{
    coef_t'(430),  coef_t'(-127), coef_t'(-48),
    coef_t'(-55),  coef_t'(464),  coef_t'(-154),
    coef_t'(10),   coef_t'(-145), coef_t'(391)
  };

  logic en, acc, apply;

  coef_t shadow [9];
  coef_t active [9];

  logic              s1_valid, s1_sof, s1_byp;
  logic [DATA_W-1:0] s1_ch [3];
  coef_t             s1_coef [9];

  logic signed [PW-1:0] prod [9];

  logic                 s2_valid, s2_sof, s2_byp;
  logic [DATA_W-1:0]    s2_ch [3];
  logic signed [PW-1:0] s2_prod [9];

  logic signed [SW-1:0] sum [3];
  logic signed [SW-1:0] shf [3];
  logic [DATA_W-1:0]    res [3];

  assign en       = out_ready | ~out_valid;
  assign in_ready = en;
  assign acc      = in_valid & en;
  assign apply    = acc & in_sof & commit_pending;

  // Shadow writes, commit arming and frame-aligned bank swap
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 9; i++) begin
        shadow[i] <= DEF[i];
        active[i] <= DEF[i];
      end
      commit_pending <= 1'b0;
    end else begin
      for (int i = 0; i < 9; i++) begin
        if (coef_we && coef_addr == 4'(i))
          shadow[i] <= coef_wdata;
        if (apply)
          active[i] <= shadow[i];
      end
      commit_pending <= coef_commit | (commit_pending & ~apply);
    end
  end

  // S1: capture beat together with the bank it must use
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_sof   <= 1'b0;
      s1_byp   <= 1'b0;
      for (int i = 0; i < 3; i++) s1_ch[i] <= '0;
      for (int i = 0; i < 9; i++) s1_coef[i] <= '0;
    end else if (en) begin
      s1_valid <= in_valid;
      s1_sof   <= in_sof;
      s1_byp   <= bypass;
      s1_ch[0] <= in_r;
      s1_ch[1] <= in_g;
      s1_ch[2] <= in_b;
      for (int i = 0; i < 9; i++)
        s1_coef[i] <= apply ? shadow[i] : active[i];
    end
  end

  // Nine full-width products, channel treated as non-negative
  always_comb begin
    for (int i = 0; i < 9; i++)
      prod[i] = PW'($signed({1'b0, s1_ch[i % 3]}))
              * PW'(s1_coef[i]);
  end

  // S2: hold products plus raw channels for bypass
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      s2_sof   <= 1'b0;
      s2_byp   <= 1'b0;
      for (int i = 0; i < 3; i++) s2_ch[i] <= '0;
      for (int i = 0; i < 9; i++) s2_prod[i] <= '0;
    end else if (en) begin
      s2_valid <= s1_valid;
      s2_sof   <= s1_sof;
      s2_byp   <= s1_byp;
      for (int i = 0; i < 3; i++) s2_ch[i] <= s1_ch[i];
      for (int i = 0; i < 9; i++) s2_prod[i] <= prod[i];
    end
  end

  // Row sums, floor shift and clamp to the channel range
  always_comb begin
    for (int r = 0; r < 3; r++) begin
      sum[r] = SW'(s2_prod[3*r])
             + SW'(s2_prod[3*r+1])
             + SW'(s2_prod[3*r+2]);
      shf[r] = sum[r] >>> FRAC_BITS;
      if (shf[r][SW-1])
        res[r] = '0;
      else if (|shf[r][SW-2:DATA_W])
        res[r] = '1;
      else
        res[r] = shf[r][DATA_W-1:0];
    end
  end

  // S3: output register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_sof   <= 1'b0;
      out_r     <= '0;
      out_g     <= '0;
      out_b     <= '0;
    end else if (en) begin
      out_valid <= s2_valid;
      out_sof   <= s2_sof;
      out_r     <= s2_byp ? s2_ch[0] : res[0];
      out_g     <= s2_byp ? s2_ch[1] : res[1];
      out_b     <= s2_byp ? s2_ch[2] : res[2];
    end
  end

endmodule

// File: tb/tb_color_correction_pipe.sv
// Scoreboard bench for color_correction_pipe.
// Driver queues expectations; monitor checks output beats.
module tb_color_correction_pipe;

  logic              clk = 0;
  logic              rst_n = 0;
  logic              in_valid = 0;
  logic              in_ready;
  logic              in_sof = 0;
  logic [15:0]       in_r = 0, in_g = 0, in_b = 0;
  logic              out_valid;
  logic              out_ready = 1;
  logic              out_sof;
  logic [15:0]       out_r, out_g, out_b;
  logic              bypass = 0;
  logic              coef_we = 0;
  logic [3:0]        coef_addr = 0;
  logic signed [11:0] coef_wdata = 0;
  logic              coef_commit = 0;
  logic              commit_pending;

  color_correction_pipe dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_sof(in_sof),
    .in_r(in_r), .in_g(in_g), .in_b(in_b),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sof(out_sof),
    .out_r(out_r), .out_g(out_g), .out_b(out_b),
    .bypass(bypass),
    .coef_we(coef_we), .coef_addr(coef_addr),
    .coef_wdata(coef_wdata),
    .coef_commit(coef_commit),
    .commit_pending(commit_pending)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        sof;
    logic [15:0] r, g, b;
  } beat_t;

  beat_t q[$];
  int total = 0;
  int bad = 0;
  bit rand_rdy = 0;

  int dc[9] = '{430, -127, -48, -55, 464, -154, 10, -145, 391};

  function automatic logic [15:0] mrow(int c0, int c1, int c2,
                                      int r, int g, int b);
    longint s;
    s = longint'(c0) * r + longint'(c1) * g + longint'(c2) * b;
    s = s >>> 8;
    if (s < 0) return 16'd0;
    if (s > 65535) return 16'hffff;
    return 16'(s);
  endfunction

  task automatic check(string name, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: compare every accepted output beat against the queue
  always begin
    @(negedge clk);
    #2;
    if (rst_n) begin
      total++;
      if (in_ready !== (out_ready | ~out_valid)) begin
        bad++;
        $display("FAIL in_ready_rule: got %0b expected %0b",
                 in_ready, out_ready | ~out_valid);
      end
      if (out_valid && out_ready) begin
        total++;
        if (q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_beat: got %0d,%0d,%0d none expected",
                   out_r, out_g, out_b);
        end else begin
          beat_t e;
          e = q.pop_front();
          if (out_sof !== e.sof || out_r !== e.r ||
              out_g !== e.g || out_b !== e.b) begin
            bad++;
            $display("FAIL beat: got sof=%0b %0d,%0d,%0d expected sof=%0b %0d,%0d,%0d",
                     out_sof, out_r, out_g, out_b,
                     e.sof, e.r, e.g, e.b);
          end
        end
      end
    end
  end

  task automatic send(int r, int g, int b, bit sof, bit byp,
                      bit push, int er, int eg, int eb);
    int n;
    beat_t e;
    in_valid = 1;
    in_sof   = sof;
    bypass   = byp;
    in_r     = 16'(r);
    in_g     = 16'(g);
    in_b     = 16'(b);
    if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
    #1;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
      #1;
      n++;
    end
    if (!in_ready) begin
      check("accept_timeout", 0, 1);
    end else if (push) begin
      e.sof = sof;
      e.r = 16'(er);
      e.g = 16'(eg);
      e.b = 16'(eb);
      q.push_back(e);
    end
    @(posedge clk);
    @(negedge clk);
    in_valid = 0;
    in_sof   = 0;
    bypass   = 0;
  endtask

  task automatic wr(int addr, int data);
    coef_we    = 1;
    coef_addr  = 4'(addr);
    coef_wdata = 12'(data);
    @(posedge clk);
    @(negedge clk);
    coef_we = 0;
  endtask

  task automatic commit();
    coef_commit = 1;
    @(posedge clk);
    @(negedge clk);
    coef_commit = 0;
  endtask

  task automatic drain();
    int n;
    out_ready = 1;
    n = 0;
    while (q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("drain_left", q.size(), 0);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int r, g, b;
    @(negedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_pending", commit_pending, 0);
    check("rst_out_r", out_r, 0);
    rst_n = 1;
    #1;
    check("rst_in_ready", in_ready, 1);
    @(negedge clk);

    send(51200, 0, 0, 0, 0, 1, 65535, 0, 2000);
    send(51200, 46080, 40960, 0, 0, 1, 55460, 47880, 38460);
    drain();

    rand_rdy = 1;
    for (int i = 0; i < 10; i++) begin
      r = 3000 * i + 1000;
      g = 65535 - 6000 * i;
      b = 7000 * i;
      send(r, g, b, i == 0, 0, 1,
           mrow(dc[0], dc[1], dc[2], r, g, b),
           mrow(dc[3], dc[4], dc[5], r, g, b),
           mrow(dc[6], dc[7], dc[8], r, g, b));
    end
    rand_rdy = 0;
    drain();

    for (int i = 0; i < 9; i++) wr(i, (i % 4 == 0) ? 256 : 0);
    commit();
    check("pending_set", commit_pending, 1);
    send(51200, 0, 0, 0, 0, 1, 65535, 0, 2000);
    check("pending_hold", commit_pending, 1);
    send(100, 200, 300, 1, 0, 1, 100, 200, 300);
    check("pending_clear", commit_pending, 0);
    send(5, 6, 7, 0, 0, 1, 5, 6, 7);

    coef_we     = 1;
    coef_addr   = 0;
    coef_wdata  = 12'sd512;
    coef_commit = 1;
    send(100, 200, 300, 1, 0, 1, 100, 200, 300);
    coef_we     = 0;
    coef_commit = 0;
    check("pending_same_cycle", commit_pending, 1);
    send(40, 50, 60, 0, 0, 1, 40, 50, 60);
    send(100, 7, 9, 1, 0, 1, 200, 7, 9);
    check("pending_clear2", commit_pending, 0);

    send(70, 80, 90, 0, 1, 1, 70, 80, 90);
    wr(12, 999);
    commit();
    send(10, 20, 30, 1, 0, 1, 20, 20, 30);
    drain();

    out_ready = 0;
    for (int i = 0; i < 3; i++)
      send(1000, 2000, 3000, 0, 0, 0, 0, 0, 0);
    commit();
    check("stall_full", out_valid, 1);
    rst_n = 0;
    #1;
    check("rst_mid_valid", out_valid, 0);
    check("rst_mid_pending", commit_pending, 0);
    check("rst_mid_out_g", out_g, 0);
    @(negedge clk);
    rst_n = 1;
    out_ready = 1;
    #1;
    check("rel_in_ready", in_ready, 1);
    repeat (8) @(negedge clk);
    send(51200, 46080, 40960, 0, 0, 1, 55460, 47880, 38460);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
